// File: rtl/mips32_mem_arbiter_if.sv
// Shared-port bus for the MIPS32 unified memory arbiter: fetch, data and memory sides.
// The slave modport is the arbiter; the master modport is the surrounding core/memory.
interface mips32_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter: data-priority with fetch starvation guard, flush-dropped
// fetch responses, 1-cycle read latency routing and grant/conflict counters.
module mips32_mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mips32_mem_arbiter_if.slave bus,
    output logic [CNT_W-1:0] if_gnt_cnt,
    output logic [CNT_W-1:0] d_gnt_cnt,
    output logic [CNT_W-1:0] conflict_cnt
);
    localparam logic [3:0]       LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_IF,
        RSP_D
    } rsp_owner_t;

    rsp_owner_t rsp_owner;
    logic [3:0] starve_cnt;
    logic       if_req_e;
    logic       if_gnt_c;
    logic       d_gnt_c;
    logic       if_rvalid_c;
    logic       d_rvalid_c;

    always_comb begin
        if_req_e = bus.if_req & ~bus.if_flush;
        // Fetch wins a conflict only once it has been denied STARVE_LIMIT times in a row.
        if_gnt_c = if_req_e & (~bus.d_req | (starve_cnt == LIMIT));
        d_gnt_c  = bus.d_req & ~if_gnt_c;

        bus.if_gnt    = if_gnt_c;
        bus.d_gnt     = d_gnt_c;
        bus.mem_en    = if_gnt_c | d_gnt_c;
        bus.mem_we    = d_gnt_c & bus.d_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (if_gnt_c) begin
            bus.mem_addr = bus.if_addr;
        end else if (d_gnt_c) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end

        // A flush in the response cycle kills the stale fetch data outright.
        if_rvalid_c   = (rsp_owner == RSP_IF) & ~bus.if_flush;
        d_rvalid_c    = (rsp_owner == RSP_D);
        bus.if_rvalid = if_rvalid_c;
        bus.d_rvalid  = d_rvalid_c;
        bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : '0;
        bus.d_rdata   = d_rvalid_c  ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_owner    <= RSP_NONE;
            starve_cnt   <= '0;
            if_gnt_cnt   <= '0;
            d_gnt_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (if_gnt_c) begin
                rsp_owner <= RSP_IF;
            end else if (d_gnt_c && !bus.d_we) begin
                rsp_owner <= RSP_D;
            end else begin
                rsp_owner <= RSP_NONE;
            end

            if (!if_req_e || if_gnt_c) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (if_gnt_c) begin
                if_gnt_cnt <= if_gnt_cnt + CNT_ONE;
            end
            if (d_gnt_c) begin
                d_gnt_cnt <= d_gnt_cnt + CNT_ONE;
            end
            if (if_req_e && bus.d_req) begin
                conflict_cnt <= conflict_cnt + CNT_ONE;
            end
        end
    end
endmodule
